// File: rtl/vdp_vram_arbiter_if.sv
// Bundle of display-fetch, CPU-bus and VRAM-port signals around the VRAM arbiter.
// master = surrounding logic (display FSM, CPU interface, block RAM); slave = arbiter.
interface vdp_vram_arbiter_if #(
  parameter int AW = 13
);
  logic [AW-1:0] vdp_dma_addr;
  logic          vdp_dma_rd_tick;
  logic          cpu_addr_load;
  logic [AW-1:0] cpu_addr_in;
  logic          cpu_prefetch;
  logic          cpu_wr_tick;
  logic [7:0]    cpu_wr_data;
  logic          cpu_rd_tick;
  logic [7:0]    cpu_rd_data;
  logic          cpu_busy;
  logic          cpu_overrun;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_din;
  logic [7:0]    vram_dout;
  logic [7:0]    stall_max;

  modport master (
    output vdp_dma_addr, vdp_dma_rd_tick,
    output cpu_addr_load, cpu_addr_in, cpu_prefetch,
    output cpu_wr_tick, cpu_wr_data, cpu_rd_tick,
    input  cpu_rd_data, cpu_busy, cpu_overrun,
    input  vram_addr, vram_we, vram_din,
    output vram_dout,
    input  stall_max
  );

  modport slave (
    input  vdp_dma_addr, vdp_dma_rd_tick,
    input  cpu_addr_load, cpu_addr_in, cpu_prefetch,
    input  cpu_wr_tick, cpu_wr_data, cpu_rd_tick,
    output cpu_rd_data, cpu_busy, cpu_overrun,
    output vram_addr, vram_we, vram_din,
    input  vram_dout,
    output stall_max
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// VRAM port arbiter: display fetch has absolute priority, CPU (TMS9918-style pointer,
// write buffer, read-ahead) takes idle slots. `VDP_VRAM_ARB_STATS_EN adds stall_max stats.
module vdp_vram_arbiter #(
  parameter int VRAM_SIZE       = 8 * 1024,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
  input  logic                    pxclk,
  input  logic                    reset,
  vdp_vram_arbiter_if.slave       vif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [VRAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]                 wr_buf_q, wr_buf_d;
  logic [7:0]                 rd_buf_q, rd_buf_d;
  logic                       overrun_q, overrun_d;
  logic                       any_strobe;

  assign any_strobe = vif.cpu_addr_load | vif.cpu_wr_tick | vif.cpu_rd_tick;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_buf_d  = wr_buf_q;
    rd_buf_d  = rd_buf_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (vif.cpu_addr_load) begin
          ptr_d     = vif.cpu_addr_in;
          overrun_d = vif.cpu_wr_tick | vif.cpu_rd_tick;
          if (vif.cpu_prefetch) state_d = RD_PEND;
        end else if (vif.cpu_wr_tick) begin
          wr_buf_d = vif.cpu_wr_data;
          state_d  = WR_PEND;
          if (vif.cpu_rd_tick) overrun_d = 1'b1;
        end else if (vif.cpu_rd_tick) begin
          state_d = RD_PEND;
        end
      end
      WR_PEND: begin
        if (!vif.vdp_dma_rd_tick) begin
          rd_buf_d = wr_buf_q;
          ptr_d    = ptr_q + VRAM_ADDR_WIDTH'(1);
          state_d  = IDLE;
        end
      end
      RD_PEND: begin
        if (!vif.vdp_dma_rd_tick) begin
          ptr_d   = ptr_q + VRAM_ADDR_WIDTH'(1);
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        // Address went out last cycle; the display may own the port now.
        rd_buf_d = vif.vram_dout;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && any_strobe) overrun_d = 1'b1;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_buf_q  <= '0;
      rd_buf_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_buf_q  <= wr_buf_d;
      rd_buf_q  <= rd_buf_d;
      overrun_q <= overrun_d;
    end
  end

  // Write enable is gated by reset so an aborted WR_PEND never reaches the RAM.
  assign vif.vram_addr   = vif.vdp_dma_rd_tick ? vif.vdp_dma_addr : ptr_q;
  assign vif.vram_we     = !vif.vdp_dma_rd_tick && (state_q == WR_PEND) && !reset;
  assign vif.vram_din    = wr_buf_q;
  assign vif.cpu_rd_data = rd_buf_q;
  assign vif.cpu_busy    = (state_q != IDLE);
  assign vif.cpu_overrun = overrun_q;

`ifdef VDP_VRAM_ARB_STATS_EN
  logic [7:0] wait_q, wait_d;
  logic [7:0] stall_max_q, stall_max_d;

  always_comb begin
    wait_d      = wait_q;
    stall_max_d = stall_max_q;
    if (state_q == IDLE && any_strobe) begin
      wait_d = '0;
    end else if ((state_q == WR_PEND || state_q == RD_PEND) && vif.vdp_dma_rd_tick) begin
      if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
    end
    if (wait_d > stall_max_q) stall_max_d = wait_d;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      wait_q      <= '0;
      stall_max_q <= '0;
    end else begin
      wait_q      <= wait_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign vif.stall_max = stall_max_q;
`else
  assign vif.stall_max = '0;
`endif

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a registered-read VRAM model.
// Inputs change 1ns after pxclk rises; outputs are checked at that same point.
module tb_vdp_vram_arbiter;
  localparam int SIZE = 8 * 1024;
  localparam int AW   = 13;

  logic pxclk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [SIZE];
  logic [7:0] exp_stall;

  vdp_vram_arbiter_if #(.AW(AW)) bus ();

  vdp_vram_arbiter #(.VRAM_SIZE(SIZE)) dut (
    .pxclk (pxclk),
    .reset (reset),
    .vif   (bus)
  );

  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) begin
    if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_din;
    bus.vram_dout <= mem[bus.vram_addr];
  end

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic pf);
    bus.cpu_addr_load = 1'b1;
    bus.cpu_addr_in   = a;
    bus.cpu_prefetch  = pf;
    step();
    bus.cpu_addr_load = 1'b0;
    bus.cpu_prefetch  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 8'h00;
    mem[13'h200] = 8'h11;
    mem[13'h201] = 8'h22;
    bus.vdp_dma_addr    = '0;
    bus.vdp_dma_rd_tick = 1'b0;
    bus.cpu_addr_load   = 1'b0;
    bus.cpu_addr_in     = '0;
    bus.cpu_prefetch    = 1'b0;
    bus.cpu_wr_tick     = 1'b0;
    bus.cpu_wr_data     = '0;
    bus.cpu_rd_tick     = 1'b0;
    bus.vram_dout       = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_rd_data", 32'(bus.cpu_rd_data), 32'h0);
    chk("rst_busy", 32'(bus.cpu_busy), 32'h0);
    chk("rst_overrun", 32'(bus.cpu_overrun), 32'h0);
    chk("rst_we", 32'(bus.vram_we), 32'h0);
    chk("rst_addr", 32'(bus.vram_addr), 32'h0);
    chk("rst_stall", 32'(bus.stall_max), 32'h0);

    // Three buffered writes from 0x100
    load(13'h100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr_tick = 1'b1;
      bus.cpu_wr_data = (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'hCC;
      step();
      bus.cpu_wr_tick = 1'b0;
      chk("wr_we_next_clk", 32'(bus.vram_we), 32'h1);
      chk("wr_addr", 32'(bus.vram_addr), 32'h100 + 32'(i));
      step();
      step();
      step();
    end
    chk("mem_100", 32'(mem[13'h100]), 32'hAA);
    chk("mem_101", 32'(mem[13'h101]), 32'hBB);
    chk("mem_102", 32'(mem[13'h102]), 32'hCC);
    chk("ptr_103", 32'(bus.vram_addr), 32'h103);
    chk("rd_after_wr", 32'(bus.cpu_rd_data), 32'hCC);

    // Prefetching load, then read-ahead on consume
    load(13'h200, 1'b1);
    chk("pf_busy", 32'(bus.cpu_busy), 32'h1);
    chk("pf_addr", 32'(bus.vram_addr), 32'h200);
    step();
    chk("pf_not_yet", 32'(bus.cpu_rd_data), 32'hCC);
    step();
    chk("pf_data", 32'(bus.cpu_rd_data), 32'h11);
    bus.cpu_rd_tick = 1'b1;
    step();
    bus.cpu_rd_tick = 1'b0;
    step();
    step();
    chk("rd_next", 32'(bus.cpu_rd_data), 32'h22);
    chk("ptr_202", 32'(bus.vram_addr), 32'h202);

    // Write held off for 5 display cycles
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_wr_data = 8'h77;
    step();
    bus.cpu_wr_tick     = 1'b0;
    bus.vdp_dma_rd_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.vdp_dma_addr = 13'h0A0 + 13'(i);
      #1;
      chk("hold_we", 32'(bus.vram_we), 32'h0);
      chk("hold_addr", 32'(bus.vram_addr), 32'h0A0 + 32'(i));
      step();
    end
    bus.vdp_dma_rd_tick = 1'b0;
    #1;
    chk("held_we_6th", 32'(bus.vram_we), 32'h1);
    chk("held_addr_6th", 32'(bus.vram_addr), 32'h202);
    step();
    chk("mem_202", 32'(mem[13'h202]), 32'h77);
`ifdef VDP_VRAM_ARB_STATS_EN
    exp_stall = 8'd5;
`else
    exp_stall = 8'd0;
`endif
    chk("stall_max", 32'(bus.stall_max), 32'(exp_stall));

    // Pointer wrap at the top of VRAM
    load(13'h1FFF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.cpu_wr_tick = 1'b1;
      bus.cpu_wr_data = 8'h5A;
      step();
      bus.cpu_wr_tick = 1'b0;
      step();
    end
    chk("mem_1fff", 32'(mem[13'h1FFF]), 32'h5A);
    chk("mem_0000", 32'(mem[13'h0000]), 32'h5A);
    chk("ptr_wrap", 32'(bus.vram_addr), 32'h1);

    // Back-to-back writes during display hold: second dropped
    bus.vdp_dma_rd_tick = 1'b1;
    bus.cpu_wr_tick     = 1'b1;
    bus.cpu_wr_data     = 8'h33;
    step();
    bus.cpu_wr_data     = 8'h44;
    step();
    bus.cpu_wr_tick     = 1'b0;
    chk("ovr_set", 32'(bus.cpu_overrun), 32'h1);
    chk("ovr_busy", 32'(bus.cpu_busy), 32'h1);
    bus.vdp_dma_rd_tick = 1'b0;
    step();
    chk("ovr_mem_1", 32'(mem[13'h0001]), 32'h33);
    chk("ovr_rd_data", 32'(bus.cpu_rd_data), 32'h33);
    chk("ovr_sticky", 32'(bus.cpu_overrun), 32'h1);
    load(13'h300, 1'b0);
    chk("ovr_clear", 32'(bus.cpu_overrun), 32'h0);

    // Reset aborts a pending write
    bus.vdp_dma_rd_tick = 1'b1;
    bus.cpu_wr_tick     = 1'b1;
    bus.cpu_wr_data     = 8'h99;
    step();
    bus.cpu_wr_tick     = 1'b0;
    chk("abort_busy", 32'(bus.cpu_busy), 32'h1);
    reset               = 1'b1;
    bus.vdp_dma_rd_tick = 1'b0;
    #1;
    chk("abort_we_in_reset", 32'(bus.vram_we), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_mem_300", 32'(mem[13'h300]), 32'h00);
    chk("abort_busy0", 32'(bus.cpu_busy), 32'h0);
    chk("abort_we0", 32'(bus.vram_we), 32'h0);
    chk("abort_addr0", 32'(bus.vram_addr), 32'h0);
    chk("abort_din0", 32'(bus.vram_din), 32'h0);
    chk("abort_rd0", 32'(bus.cpu_rd_data), 32'h0);
    chk("abort_stall0", 32'(bus.stall_max), 32'h0);
    step();
    chk("abort_no_late_wr", 32'(mem[13'h300]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
